cell_buffer_arbiter: RTL
========================

CELL_BUFFER_ARBITER -- requirements
Module: cell_buffer_arbiter

Interface
REQ-001 SHALL take parameter CELL_HORIZONTAL_LENGHT, default 36, number of cell columns.
REQ-002 SHALL take parameter CELL_VERTICAL_LENGHT, default 20, number of cell rows; N = product (720), AW = $clog2(N) (10).
REQ-003 SHALL take parameter CLEAR_VALUE, default 8'h00, the value written to every cell by a clear.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port wr_req, input, 1 bit: single-cycle write request (button strobe).
REQ-007 SHALL have port wr_data, input, 8 bits: cell value sampled with wr_req.
REQ-008 SHALL have port clr_req, input, 1 bit: single-cycle clear request.
REQ-009 SHALL have port rd_req, input, 1 bit: display read request (vga_drawer side).
REQ-010 SHALL have port rd_addr, input, AW bits: cell index for the read.
REQ-011 SHALL have port rd_data, output, 8 bits: read result.
REQ-012 SHALL have port rd_valid, output, 1 bit: rd_data is valid this cycle.
REQ-013 SHALL have ports mem_addr (output, AW), mem_we (output, 1), mem_wdata (output, 8) and mem_rdata (input, 8): single-port synchronous RAM with 1-cycle read latency.
REQ-014 SHALL have port wr_ptr, output, AW bits: next cell index to be written.
REQ-015 SHALL have port wr_ack, output, 1 bit: one-cycle pulse when a write commits to RAM.
REQ-016 SHALL have port busy, output, 1 bit: high while a clear is in progress.

Function
REQ-017 SHALL grant the RAM port each cycle by fixed priority: rd_req, then clear sequencer, then pending write.
REQ-018 SHALL drive mem_addr=rd_addr and mem_we=0 on a granted read, then assert rd_valid the following cycle with rd_data=mem_rdata.
REQ-019 SHALL return rd_data=8'h00 with rd_valid=1 for rd_addr>=N, without a RAM read.
REQ-020 SHALL latch wr_data into a 1-entry hold register on wr_req; a wr_req arriving while the hold is occupied SHALL be ignored (no ack, no state change).
REQ-021 SHALL commit the held write on the first cycle granted (mem_we=1, mem_addr=wr_ptr), pulse wr_ack that cycle, and free the hold.
REQ-022 SHALL let a wr_req that arrives in the same cycle a held write commits occupy the hold register for the next grant.
REQ-023 SHALL increment wr_ptr after each commit, wrapping from N-1 to 0.
REQ-024 SHALL implement FSM states IDLE and CLEAR; IDLE->CLEAR on clr_req, CLEAR->IDLE after address N-1 is written.
REQ-025 SHALL write CLEAR_VALUE to addresses 0..N-1 in ascending order in CLEAR, one per granted cycle, stalling (not skipping) while rd_req=1; a clear takes exactly N cycles with rd_req=0.
REQ-026 SHALL set wr_ptr=0 on leaving CLEAR; clr_req in CLEAR SHALL be ignored; busy=1 exactly while in CLEAR.
REQ-027 SHALL still latch wr_req in CLEAR, with the held write committing after the clear at address 0.
REQ-028 SHALL give clear priority over a simultaneous wr_req in IDLE; the write is held and commits after the clear.

Reset
REQ-029 SHALL on rst force: state IDLE, wr_ptr=0, hold empty, rd_valid=0, rd_data=0, wr_ack=0, busy=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-030 SHALL abort an in-progress clear or pending write on rst (RAM left partially written); rst overrides all requests in the same cycle.

Configuration
REQ-031 SHALL, with CELL_ARB_CLEAR_EN defined, implement the CLEAR state, clr_req and busy as specified.
REQ-032 SHALL, without CELL_ARB_CLEAR_EN, omit the clear sequencer: clr_req ignored, busy tied 0, FSM permanently IDLE.

Verification
REQ-033 SHALL: reset, then wr_req with 8'h41 and rd_req=0 -> wr_ack 1 cycle later at mem_addr 0; wr_ptr=1; read addr 0 -> rd_data 8'h41.
REQ-034 SHALL: 720 writes (i mod 256) -> wr_ptr wraps to 0; the 721st write lands at address 0.
REQ-035 SHALL: wr_req 8'h55 with rd_req held high 10 cycles -> no mem_we during hold; commit in first rd_req=0 cycle; second wr_req during hold ignored.
REQ-036 SHALL: (CELL_ARB_CLEAR_EN) clr_req with rd_req=0 -> busy for exactly 720 cycles, all cells 8'h00, wr_ptr=0; rd_req pulses inside the clear extend busy by one cycle each.
REQ-037 SHALL: clr_req and wr_req 8'h7F same cycle -> clear completes, then 8'h7F commits at address 0, wr_ptr=1.
REQ-038 SHALL: rst asserted at clear cycle 300 -> next cycle busy=0, wr_ptr=0, cells >=300 unchanged.

Source files
------------

// File: rtl/cell_buffer_arbiter.sv
// cell_buffer_arbiter: arbitrates one single-port cell RAM between display reads, a clear sequencer and a held write.
// Optional feature: define CELL_ARB_CLEAR_EN to build the clear sequencer (clr_req, busy, CLEAR state).
// Ports: clk, rst (sync, active-high); wr_req/wr_data -> 1-entry hold, committed at wr_ptr with a wr_ack pulse;
// clr_req starts a clear, busy high while clearing; rd_req/rd_addr -> rd_data/rd_valid one cycle later;
// mem_addr/mem_we/mem_wdata/mem_rdata drive a synchronous RAM with 1-cycle read latency.
module cell_buffer_arbiter #(
    parameter int         CELL_HORIZONTAL_LENGHT = 36,
    parameter int         CELL_VERTICAL_LENGHT   = 20,
    parameter logic [7:0] CLEAR_VALUE            = 8'h00,
    localparam int        N  = CELL_HORIZONTAL_LENGHT * CELL_VERTICAL_LENGHT,
    localparam int        AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req,
    input  logic [7:0]    wr_data,
    input  logic          clr_req,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic [AW-1:0] wr_ptr,
    output logic          wr_ack,
    output logic          busy
);
`ifdef CELL_ARB_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t        state;
    logic          hold_v;
    logic [7:0]    hold_d;
    logic [AW-1:0] clr_addr;
    logic          rd_oob;
    logic          clr_go;
    logic          wr_go;
    logic          clr_last;
    assign busy = state == CLEAR;
    // Reads always win the port; reset forces every RAM-side output quiet in the same cycle.
    always_comb begin
        clr_go    = !rd_req && state == CLEAR;
        wr_go     = !rd_req && state == IDLE && hold_v;
        clr_last  = clr_go && clr_addr == AW'(N - 1);
        mem_we    = !rst && (clr_go || wr_go);
        wr_ack    = !rst && wr_go;
        mem_addr  = rst ? '0 : rd_req ? rd_addr : clr_go ? clr_addr : wr_ptr;
        mem_wdata = rst ? '0 : clr_go ? CLEAR_VALUE : hold_d;
        rd_data   = rd_valid && !rd_oob ? mem_rdata : 8'h00;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            hold_v   <= 1'b0;
            hold_d   <= 8'h00;
            clr_addr <= '0;
            rd_valid <= 1'b0;
            rd_oob   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            rd_oob   <= int'(rd_addr) >= N;
            // A request landing on the commit cycle refills the slot being freed.
            if (wr_req && (!hold_v || wr_go)) begin
                hold_v <= 1'b1;
                hold_d <= wr_data;
            end else if (wr_go) begin
                hold_v <= 1'b0;
            end
            if (wr_go)
                wr_ptr <= wr_ptr == AW'(N - 1) ? '0 : wr_ptr + AW'(1);
            if (state == IDLE && clr_req && CLR_EN) begin
                state    <= CLEAR;
                clr_addr <= '0;
            end else if (clr_last) begin
                state  <= IDLE;
                wr_ptr <= '0;
            end else if (clr_go) begin
                clr_addr <= clr_addr + AW'(1);
            end
        end
    end
endmodule
